// File: rtl/frame_pkg.sv
// Shared constants, FSM states and payload types for the parameter frame loader.
// FRAME_CHECKSUM_EN adds a trailing XOR checksum word to every frame.
package frame_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned JID_ENTRIES  = 6;
  localparam int unsigned JID_W        = 64;
  localparam int unsigned URZRAF_LANES = 5;
`ifdef FRAME_CHECKSUM_EN
  localparam int unsigned FRAME_WORDS  = 15;
`else
  localparam int unsigned FRAME_WORDS  = 14;
`endif
  localparam int unsigned JID_LAST_WORD = 11;
  localparam int unsigned INT_WORD      = 12;
  localparam int unsigned ARR_WORD      = 13;
  localparam int unsigned CSUM_WORD     = 14;
  localparam int unsigned CNT_W         = 4;
  localparam int unsigned GAP_W         = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_JID,
    LOAD_INT,
    LOAD_ARR,
    CHECK,
    COMMIT
  } state_t;

  typedef logic [JID_ENTRIES-1:0][JID_W-1:0] jid_t;
  typedef logic [URZRAF_LANES-1:0][1:0]      urzraf_t;

endpackage

// File: rtl/param_frame_loader_if.sv
// Inbound word stream (valid/ready) for the parameter frame loader.
interface param_frame_loader_if;
  import frame_pkg::*;

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/frame_xor_acc.sv
// Running XOR accumulator with clear/enable; only built with FRAME_CHECKSUM_EN.
`ifdef FRAME_CHECKSUM_EN
module frame_xor_acc
  import frame_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] acc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule
`endif

// File: rtl/param_frame_loader.sv
// Collects a parameter frame into shadow registers and commits all fields at once.
// Optional FRAME_CHECKSUM_EN: 15-word frames whose last word is the XOR of words 0-13.
module param_frame_loader
  import frame_pkg::*;
#(
  parameter int unsigned GAP_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  param_frame_loader_if.slave           s,
  input  logic                          abort_i,
  output logic [JID_ENTRIES*JID_W-1:0]  jid_o,
  output logic signed [WORD_W-1:0]      efammlu_o,
  output logic [URZRAF_LANES*2-1:0]     urzraf_o,
  output logic                          frame_valid_o,
  output logic                          commit_o,
  output logic                          err_o
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [GAP_W-1:0]  gap;
  jid_t              sh_jid;
  logic [WORD_W-1:0] sh_int;
  urzraf_t           sh_arr;
  logic              ready_q;

  logic in_load_c, accept_c, gap_hit_c, check_ok_c, ready_nxt_c;
  logic take_c, drop_c, commit_c;

  assign s.s_ready   = ready_q;
  assign accept_c    = s.s_valid & ready_q;
  assign in_load_c   = (state == LOAD_JID) || (state == LOAD_INT) || (state == LOAD_ARR);
  assign gap_hit_c   = in_load_c && !accept_c && (gap == GAP_W'(GAP_TIMEOUT - 1));
  assign ready_nxt_c = (state_nxt != CHECK) && (state_nxt != COMMIT);

`ifdef FRAME_CHECKSUM_EN
  logic [WORD_W-1:0] sh_csum, xor_acc;
  logic              xor_clr_c, xor_en_c;

  assign xor_clr_c  = drop_c || (state == COMMIT);
  assign xor_en_c   = take_c && (cnt < CNT_W'(CSUM_WORD));
  assign check_ok_c = (xor_acc == sh_csum);

  frame_xor_acc u_xor_acc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (xor_clr_c),
    .en   (xor_en_c),
    .din  (s.s_data),
    .acc  (xor_acc)
  );
`else
  assign check_ok_c = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Abort or gap timeout inside a LOAD state wins over a word accepted that cycle.
  always_comb begin
    state_nxt = state;
    take_c    = 1'b0;
    drop_c    = 1'b0;
    commit_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept_c) begin
          take_c    = 1'b1;
          state_nxt = LOAD_JID;
        end
      end
      LOAD_JID, LOAD_INT, LOAD_ARR: begin
        if (abort_i || gap_hit_c) begin
          drop_c    = 1'b1;
          state_nxt = IDLE;
        end else if (accept_c) begin
          take_c = 1'b1;
          if (state == LOAD_JID && cnt == CNT_W'(JID_LAST_WORD)) state_nxt = LOAD_INT;
          else if (state == LOAD_INT)                             state_nxt = LOAD_ARR;
          else if (state == LOAD_ARR && cnt == CNT_W'(FRAME_WORDS - 1)) state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (check_ok_c) begin
          commit_c  = 1'b1;
          state_nxt = COMMIT;
        end else begin
          drop_c    = 1'b1;
          state_nxt = IDLE;
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q       <= 1'b0;
      cnt           <= '0;
      gap           <= '0;
      sh_jid        <= '0;
      sh_int        <= '0;
      sh_arr        <= '0;
      jid_o         <= '0;
      efammlu_o     <= '0;
      urzraf_o      <= '0;
      frame_valid_o <= 1'b0;
      commit_o      <= 1'b0;
      err_o         <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      sh_csum       <= '0;
`endif
    end else begin
      ready_q  <= ready_nxt_c;
      commit_o <= commit_c;
      err_o    <= drop_c;

      if (drop_c) begin
        cnt    <= '0;
        gap    <= '0;
        sh_jid <= '0;
        sh_int <= '0;
        sh_arr <= '0;
`ifdef FRAME_CHECKSUM_EN
        sh_csum <= '0;
`endif
      end else if (take_c) begin
        cnt <= cnt + CNT_W'(1);
        gap <= '0;
        // Words 0..11 fill jid entries low half first, then high half.
        if (cnt <= CNT_W'(JID_LAST_WORD)) begin
          sh_jid[cnt[3:1]][{cnt[0], 5'd0} +: WORD_W] <= s.s_data;
        end else if (cnt == CNT_W'(INT_WORD)) begin
          sh_int <= s.s_data;
        end else if (cnt == CNT_W'(ARR_WORD)) begin
          sh_arr <= s.s_data[URZRAF_LANES*2-1:0];
        end
`ifdef FRAME_CHECKSUM_EN
        else begin
          sh_csum <= s.s_data;
        end
`endif
      end else if (in_load_c) begin
        gap <= gap + GAP_W'(1);
      end else if (state == COMMIT) begin
        cnt <= '0;
      end

      if (commit_c) begin
        jid_o         <= sh_jid;
        efammlu_o     <= sh_int;
        urzraf_o      <= sh_arr;
        frame_valid_o <= 1'b1;
      end
    end
  end

endmodule

// File: doc/param_frame_loader.md
PARAM_FRAME_LOADER -- requirements
Module: param_frame_loader

Interface
REQ-001 Parameter GAP_TIMEOUT, default 255: maximum idle cycles allowed between accepted words inside a frame (range 1..65535).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 s_data  input  32  inbound word.
REQ-005 s_valid  input  1  s_data is valid.
REQ-006 s_ready  output  1  loader accepts s_data this cycle.
REQ-007 abort_i  input  1  discard the frame in progress.
REQ-008 jid_o  output  384  six 64-bit signed entries, row-major [r0c3, r0c2, r0c1, r1c3, r1c2, r1c1]; entry 0 at LSBs.
REQ-009 efammlu_o  output  32  signed integer field.
REQ-010 urzraf_o  output  10  five 2-bit lanes, lane 4 at MSBs.
REQ-011 frame_valid_o  output  1  high once at least one frame has been committed.
REQ-012 commit_o  output  1  one-cycle pulse when the outputs update.
REQ-013 err_o  output  1  one-cycle pulse when a frame is dropped.

Function
REQ-014 A word is accepted when s_valid && s_ready; s_data SHALL be held by the source until accepted.
REQ-015 A frame SHALL be 14 words: words 0-11 carry jid entries 0-5 (low word first, then high word); word 12 carries efammlu; word 13 bits [9:0] carry urzraf, and bits [31:10] are ignored.
REQ-016 The FSM SHALL have the states IDLE, LOAD_JID, LOAD_INT, LOAD_ARR, CHECK and COMMIT.
REQ-017 Transitions: IDLE->LOAD_JID on the first accepted word; LOAD_JID->LOAD_INT after word 11; LOAD_INT->LOAD_ARR after word 12; LOAD_ARR->CHECK after word 13; CHECK->COMMIT; COMMIT->IDLE.
REQ-018 Words SHALL be written to shadow registers; the outputs SHALL remain unchanged until COMMIT.
REQ-019 In COMMIT, all shadow fields SHALL copy to jid_o, efammlu_o and urzraf_o in the same edge, commit_o SHALL pulse, and frame_valid_o SHALL be set.
REQ-020 s_ready SHALL be high in IDLE, LOAD_JID, LOAD_INT and LOAD_ARR, and low in CHECK and COMMIT.
REQ-021 Latency from acceptance of the last frame word to the commit_o pulse SHALL be 2 cycles.
REQ-022 A gap counter SHALL count cycles without an accepted word while in a LOAD state; when it reaches GAP_TIMEOUT, the frame SHALL be dropped.
REQ-023 abort_i in a LOAD state SHALL drop the frame and take priority over a word accepted in the same cycle.
REQ-024 abort_i in IDLE, CHECK or COMMIT SHALL be ignored.
REQ-025 On a drop, the FSM SHALL return to IDLE, the shadow registers and word count SHALL clear, err_o SHALL pulse, and the outputs SHALL retain their last committed values.
REQ-026 A frame starting the cycle after COMMIT SHALL be accepted without a bubble beyond IDLE.

Reset
REQ-027 While rst_n is low: FSM=IDLE, s_ready=0, all outputs=0, shadow registers=0, counters=0.
REQ-028 s_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-029 Reset during a frame SHALL discard the frame, and err_o SHALL not pulse.

Configuration
REQ-030 With FRAME_CHECKSUM_EN defined, a frame SHALL be 15 words; word 14 SHALL equal the XOR of words 0-13.
REQ-031 With FRAME_CHECKSUM_EN defined, a checksum mismatch in CHECK SHALL drop the frame per REQ-025, with no COMMIT.
REQ-032 Without FRAME_CHECKSUM_EN, frames SHALL be 14 words and CHECK SHALL always pass.

Structure
REQ-033 Package frame_pkg SHALL hold the constants FRAME_WORDS, JID_ENTRIES=6, the word offsets, the state enum, and the typedefs jid_t (six longint entries) and urzraf_t (logic [4:0][1:0]).
REQ-034 Sub-module frame_xor_acc SHALL hold the running XOR with clear/enable; it is instantiated only under FRAME_CHECKSUM_EN.

Verification
REQ-035 Scenario: after reset, stream words 0x1..0xE back-to-back -> commit_o pulses 2 cycles after the last word; jid_o entry0 = 0x00000002_00000001; efammlu_o = 0xD; urzraf_o = 0x00E.
REQ-036 Scenario: send 5 words, then assert abort_i -> err_o pulses; outputs stay 0 and frame_valid_o stays 0; a following full frame commits.
REQ-037 Scenario: GAP_TIMEOUT=4, send 3 words, then hold s_valid low for 4 cycles -> err_o pulses and the FSM returns to IDLE.
REQ-038 Scenario: two frames with s_valid held constantly high -> s_ready is low for exactly 2 cycles between them, and the second commit shows the second frame's values.
REQ-039 Scenario: with FRAME_CHECKSUM_EN defined, send a frame whose checksum is off by one bit -> err_o pulses, no commit, outputs unchanged; a correct checksum -> commit.
REQ-040 Scenario: pull rst_n low at word 7 -> all outputs are 0, no err_o; after release, a full frame commits normally.
